iir_sample_tx: RTL and testbench
================================

# iir_sample_tx

Serial output transmitter for the IIR filter datapath. It accepts 16-bit filtered samples (the filter's `data_out`) through a valid/ready port and buffers them in a small FIFO. Each sample is then sent as a framed, MSB-first serial word at a programmable bit rate. It is the outbound end of the filter's sample interface and drives the off-block serial link that carries filtered data to a downstream receiver or capture device.

## Interface
- `WIDTH`, 16: sample width in bits; also bits per frame.
- `DEPTH`, 4: FIFO depth in samples; power of two, at least 2.
- `CLK_DIV`, 4: `clk` cycles per serial bit; at least 2.

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_in`  in  WIDTH  sample from the filter; two's complement, passed through unchanged.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  FIFO not full.
- `tx_data`  out  1  serial data, MSB first.
- `tx_sync`  out  1  high for the whole MSB bit period of each frame.
- `tx_busy`  out  1  a frame is in progress.
- `fifo_level`  out  $clog2(DEPTH)+1  number of samples currently buffered.
- `overflow`  out  1  sticky; a valid sample was dropped.

## Operation
- **Reset.** While `reset`=0, all state clears immediately:
  - FIFO empty, `fifo_level`=0, `sample_ready`=1.
  - `tx_data`=0, `tx_sync`=0, `tx_busy`=0, `overflow`=0.
  - Divider counter = 0; FSM in IDLE.
- **Bit divider.**
  - `div_cnt` counts 0..CLK_DIV-1 and wraps. It is free-running from reset release and is not gated by FSM state.
  - `tick` = (`div_cnt` == CLK_DIV-1).
- **Push.**
  - `sample_ready` = (`fifo_level` < DEPTH), evaluated on the level at the start of the cycle.
  - `sample_valid` && `sample_ready`: the sample is written.
  - `sample_valid` && !`sample_ready`: the sample is dropped and `overflow` is set. `overflow` clears only on reset.
  - A push and a pop in the same cycle leave the level unchanged.
- **FSM.** States are IDLE and SHIFT. `bit_cnt` runs 0..WIDTH-1.
  - IDLE, on `tick` with FIFO non-empty:
    - Pop the head into the shift register.
    - Drive `tx_data` = sample MSB; set `tx_sync`=1 and `tx_busy`=1.
    - Set `bit_cnt`=0 and go to SHIFT.
  - SHIFT, on `tick`:
    - If `bit_cnt` < WIDTH-1: shift left, drive the next bit, `bit_cnt`+1, `tx_sync`=0.
    - If `bit_cnt` = WIDTH-1 and FIFO non-empty: pop the next sample and start a new frame back-to-back (MSB, `tx_sync`=1, no idle bit).
    - If `bit_cnt` = WIDTH-1 and FIFO empty: `tx_data`=0, `tx_busy`=0, go to IDLE.
  - In IDLE, `tx_data` is held at 0.
- **Unused inputs.** `sample_in` is ignored whenever `sample_valid`=0.

## Timing
- All outputs are registered and change only on a `tick` edge; push-side outputs are the exception.
- Push-side outputs (`fifo_level`, `sample_ready`, `overflow`) update on the clock edge after the push or pop.
- Each bit is held for exactly CLK_DIV cycles; a frame lasts WIDTH×CLK_DIV cycles.
- Push-to-first-bit latency when idle and empty: the first bit appears on the next `tick` edge, between 1 and CLK_DIV cycles later depending on `div_cnt`.
- Sustained throughput is one sample per WIDTH×CLK_DIV cycles. A faster producer fills the FIFO and then sets `overflow`.
- A reset asserted mid-frame aborts the frame at once. The partial word is lost, and the next frame starts only after new samples arrive.

## Structure
- Shared package `iir_pkg` holds:
  - `IIR_SAMPLE_W` = 16, the default for WIDTH.
  - The FSM state typedef (IDLE, SHIFT).
- One sub-module, `iir_sample_fifo`: a synchronous FIFO with WIDTH and DEPTH parameters, push/pop ports, level, full and empty, and async active-low `reset`.
- The FSM, divider and shift register live in the top module.

## Test plan
All scenarios use WIDTH=16, DEPTH=4, CLK_DIV=4.
- **Reset values.** Pulse `reset` low for 3 cycles with `sample_valid`=1 → during and after reset: `tx_data`=0, `tx_sync`=0, `tx_busy`=0, `fifo_level`=0, `sample_ready`=1, `overflow`=0.
- **Single frame.** Push 16'hA5C3 once while idle:
  - `tx_sync` is high for 4 cycles alongside the first bit.
  - `tx_data` carries 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each bit for 4 cycles.
  - After 64 cycles: `tx_busy`=0 and `tx_data`=0.
- **Back-to-back frames.** Push 16'h0001 then 16'h8000 on consecutive cycles → 32 contiguous bit periods with no idle bit. `tx_sync` pulses at bit 0 and at bit 16. The serial stream is fifteen 0s, 1, 1, fifteen 0s.
- **Overflow.** Starting on the cycle where `div_cnt`=0 after reset, push words 1..8 on 8 consecutive cycles:
  - Words 1..5 are accepted; the first pop occurs on the cycle-3 tick.
  - Words 6..8 are dropped and `overflow`=1 stays set.
  - The serial output is words 1..5 in order.
- **Reset mid-frame.** Assert `reset` during bit 7 of 16'hFFFF → `tx_data`=0 and `tx_busy`=0 immediately, and the FIFO is cleared. After release with no pushes, `tx_data` stays 0 for 200 cycles.
- **Simultaneous push/pop at full.** With the FIFO full, assert `sample_valid` on the pop cycle → the sample is dropped (ready was low), `overflow`=1, and `fifo_level` goes 4→3.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter sample path.
//   IIR_SAMPLE_W : default filtered-sample width
//   tx_state_e   : serial transmitter FSM states
package iir_pkg;

  localparam int unsigned IIR_SAMPLE_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/iir_sample_fifo.sv
// Synchronous sample FIFO feeding the serial transmitter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write request and data (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_data         : head of the FIFO (valid when not empty)
//   o_level        : number of entries held
//   o_full/o_empty : level == DEPTH / level == 0
module iir_sample_fifo
  import iir_pkg::*;
#(
  parameter int unsigned WIDTH = IIR_SAMPLE_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == (PW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr];
  assign o_level   = r_level;

  // Storage needs no reset; the empty flag guards stale contents.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (PW+1)'(1);
        2'b01:   r_level <= r_level - (PW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/iir_sample_tx.sv
// Serial transmitter for filtered IIR samples. Samples are buffered in a
// small FIFO and sent as MSB-first frames of WIDTH bits, CLK_DIV clocks per
// bit, with back-to-back frames when more data is waiting.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_sample_in      : two's complement sample from the filter
//   i_sample_valid   : sample valid this cycle
//   o_sample_ready   : FIFO not full
//   o_tx_data        : serial data, MSB first (0 when idle)
//   o_tx_sync        : high during the MSB bit period of each frame
//   o_tx_busy        : frame in progress
//   o_fifo_level     : samples buffered
//   o_overflow       : sticky, a valid sample was dropped
module iir_sample_tx
  import iir_pkg::*;
#(
  parameter int unsigned WIDTH   = IIR_SAMPLE_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [WIDTH-1:0]        i_sample_in,
  input  logic                    i_sample_valid,
  output logic                    o_sample_ready,
  output logic                    o_tx_data,
  output logic                    o_tx_sync,
  output logic                    o_tx_busy,
  output logic [$clog2(DEPTH):0]  o_fifo_level,
  output logic                    o_overflow
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [DivW-1:0] DIV_LAST = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BIT_LAST = CntW'(WIDTH - 1);

  logic [DivW-1:0]  r_div_cnt;
  logic [CntW-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  tx_state_e        r_state, w_state_nxt;
  logic             r_tx_data, w_tx_data_nxt;
  logic             r_tx_sync, w_tx_sync_nxt;
  logic             r_tx_busy, w_tx_busy_nxt;
  logic             r_overflow;

  logic             w_tick;
  logic             w_last_bit;
  logic             w_load;
  logic [WIDTH-1:0] w_fifo_data;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  iir_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_sample_valid),
    .i_data  (i_sample_in),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_level (o_fifo_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_last_bit = (r_bit_cnt == BIT_LAST);
  // Start a frame from idle, or chain one directly after the last bit.
  assign w_load     = w_tick && !w_fifo_empty &&
                      ((r_state == ST_IDLE) || w_last_bit);

  // Divider runs free from reset release, independent of the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DivW'(1);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_data_nxt = r_tx_data;
    w_tx_sync_nxt = r_tx_sync;
    w_tx_busy_nxt = r_tx_busy;
    if (w_load) begin
      w_shreg_nxt   = w_fifo_data;
      w_tx_data_nxt = w_fifo_data[WIDTH-1];
      w_tx_sync_nxt = 1'b1;
      w_tx_busy_nxt = 1'b1;
      w_bit_cnt_nxt = '0;
      w_state_nxt   = ST_SHIFT;
    end else if (w_tick && (r_state == ST_SHIFT)) begin
      w_tx_sync_nxt = 1'b0;
      if (!w_last_bit) begin
        w_shreg_nxt   = r_shreg << 1;
        w_tx_data_nxt = r_shreg[WIDTH-2];
        w_bit_cnt_nxt = r_bit_cnt + CntW'(1);
      end else begin
        w_tx_data_nxt = 1'b0;
        w_tx_busy_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_tx_data <= 1'b0;
      r_tx_sync <= 1'b0;
      r_tx_busy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_sync <= w_tx_sync_nxt;
      r_tx_busy <= w_tx_busy_nxt;
    end
  end

  // A sample offered while full is lost; remember it until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_sample_valid && w_fifo_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_sample_ready = !w_fifo_full;
  assign o_tx_data      = r_tx_data;
  assign o_tx_sync      = r_tx_sync;
  assign o_tx_busy      = r_tx_busy;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_iir_sample_tx.sv
// Directed bench for iir_sample_tx (WIDTH=16, DEPTH=4, CLK_DIV=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_iir_sample_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        tx_data;
  logic        tx_sync;
  logic        tx_busy;
  logic [2:0]  fifo_level;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_lvl [8] = '{0, 1, 2, 3, 3, 4, 4, 4};

  iir_sample_tx #(
    .WIDTH   (16),
    .DEPTH   (4),
    .CLK_DIV (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_in    (sample_in),
    .i_sample_valid (sample_valid),
    .o_sample_ready (sample_ready),
    .o_tx_data      (tx_data),
    .o_tx_sync      (tx_sync),
    .o_tx_busy      (tx_busy),
    .o_fifo_level   (fifo_level),
    .o_overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag, input int lvl, input int ovf);
    chk({tag, "_data"},  32'(tx_data), 0);
    chk({tag, "_sync"},  32'(tx_sync), 0);
    chk({tag, "_busy"},  32'(tx_busy), 0);
    chk({tag, "_level"}, 32'(fifo_level), 32'(lvl));
    chk({tag, "_ready"}, 32'(sample_ready), (lvl < 4) ? 1 : 0);
    chk({tag, "_ovf"},   32'(overflow), 32'(ovf));
  endtask

  // Bounded wait for the start of a frame.
  task automatic wait_sync(input string tag);
    for (int i = 0; i < 16 && !tx_sync; i++) @(negedge clk);
    chk(tag, 32'(tx_sync), 1);
  endtask

  // Called on the first cycle of bit 'first'; returns on the cycle after the frame.
  task automatic check_frame(input logic [15:0] word, input int first, input string tag);
    for (int b = first; b < 16; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, "_data"}, 32'(tx_data), 32'(word[15-b]));
        chk({tag, "_sync"}, 32'(tx_sync), (b == 0) ? 1 : 0);
        chk({tag, "_busy"}, 32'(tx_busy), 1);
        @(negedge clk);
      end
    end
  endtask

  task automatic push1(input logic [15:0] w);
    sample_valid = 1'b1;
    sample_in    = w;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    int bad;
    rst_n        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'h1234;
    #2 rst_n = 1'b0;

    // Reset values, with valid held high through reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("rst_during", 0, 0);
    end
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    chk_idle("rst_release", 0, 0);
    @(negedge clk);
    chk_idle("rst_after", 0, 0);

    // Single frame.
    push1(16'hA5C3);
    wait_sync("single_start");
    check_frame(16'hA5C3, 0, "single");
    chk_idle("single_end", 0, 0);

    // Back-to-back frames.
    push1(16'h0001);
    push1(16'h8000);
    wait_sync("b2b_start");
    check_frame(16'h0001, 0, "b2b_w0");
    check_frame(16'h8000, 0, "b2b_w1");
    chk_idle("b2b_end", 0, 0);

    // Overflow: pushes start on the div_cnt==0 cycle after reset.
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("ovf_level", 32'(fifo_level), 32'(exp_lvl[c]));
      chk("ovf_ready", 32'(sample_ready), (exp_lvl[c] < 4) ? 1 : 0);
      chk("ovf_flag",  32'(overflow), (c >= 6) ? 1 : 0);
      chk("ovf_sync",  32'(tx_sync), (c >= 4) ? 1 : 0);
      chk("ovf_busy",  32'(tx_busy), (c >= 4) ? 1 : 0);
      sample_valid = 1'b1;
      sample_in    = 16'(c + 1);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("ovf_flag_hold", 32'(overflow), 1);
    chk("ovf_level_full", 32'(fifo_level), 4);
    check_frame(16'd1, 1, "ovf_w1");
    check_frame(16'd2, 0, "ovf_w2");
    check_frame(16'd3, 0, "ovf_w3");
    check_frame(16'd4, 0, "ovf_w4");
    check_frame(16'd5, 0, "ovf_w5");
    chk_idle("ovf_end", 0, 1);

    // Reset mid-frame during bit 7 of 16'hFFFF.
    push1(16'hFFFF);
    push1(16'h1234);
    wait_sync("midrst_start");
    cyc(29);
    chk("midrst_pre_data", 32'(tx_data), 1);
    chk("midrst_pre_level", 32'(fifo_level), 1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst_async", 0, 0);
    @(negedge clk);
    cyc(1);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_data !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    chk("midrst_quiet_cycles", 32'(bad), 0);
    chk_idle("midrst_end", 0, 0);

    // Push while full on the pop cycle: dropped, level 4 -> 3.
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample_valid = 1'b1;
      sample_in    = 16'(16'h0100 + c);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    cyc(62);
    chk("full_pre_level", 32'(fifo_level), 4);
    chk("full_pre_ready", 32'(sample_ready), 0);
    chk("full_pre_ovf",   32'(overflow), 0);
    chk("full_pre_sync",  32'(tx_sync), 0);
    sample_valid = 1'b1;
    sample_in    = 16'hDEAD;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("full_post_level", 32'(fifo_level), 3);
    chk("full_post_ready", 32'(sample_ready), 1);
    chk("full_post_ovf",   32'(overflow), 1);
    chk("full_post_sync",  32'(tx_sync), 1);
    chk("full_post_data",  32'(tx_data), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
